// File: rtl/maze_player_controller.sv
// Purpose: tracks the player cell on the 10x15 maze, blocks moves through walls/edges, counts moves, detects the exit.
// Latency: a move request is evaluated on the edge it is seen; position/count/bump/won change right after that edge.
// Backpressure: none; gen_busy restarts the game. Option MAZE_PLAYER_NOCLIP_EN ignores wall bits (only grid edges block).
module maze_player_controller #(
  parameter int unsigned REPEAT_DELAY  = 12500000,
  parameter int unsigned REPEAT_PERIOD = 2500000,
  parameter int unsigned EXIT_X        = 9,
  parameter int unsigned EXIT_Y        = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [159:0] h_walls,
  input  logic [164:0] v_walls,
  input  logic         gen_busy,
  input  logic [3:0]   btn,
  output logic [3:0]   player_x,
  output logic [3:0]   player_y,
  output logic [9:0]   move_count,
  output logic         bump,
  output logic         won
);

  typedef enum logic [1:0] {WAIT_GEN, PLAY, WON} state_t;

  state_t      state, state_nxt;
  logic        armed, armed_nxt;
  logic [3:0]  btn_prev;
  logic [31:0] rpt_cnt, rpt_cnt_nxt;
  logic        rpt_on, rpt_on_nxt;     // first auto-repeat of this hold has fired
  logic [3:0]  x_nxt, y_nxt;
  logic [9:0]  cnt_nxt;
  logic        bump_nxt;

  logic        one_hot, held, rpt_fire, move_req, blocked;
  logic [3:0]  tx, ty;
  logic [7:0]  idx_up, idx_dn, idx_lf, idx_rt;
  logic        wall_up, wall_dn, wall_lf, wall_rt;

  assign won = (state == WON);

  // Auto-repeat: counter runs only while the same single button stays held.
  always_comb begin
    one_hot     = $onehot(btn);
    held        = one_hot && (btn == btn_prev);
    rpt_fire    = held && (rpt_cnt == (rpt_on ? (REPEAT_PERIOD - 1) : (REPEAT_DELAY - 1)));
    move_req    = one_hot && ((btn_prev == 4'd0) || rpt_fire);
    rpt_cnt_nxt = 32'd0;
    rpt_on_nxt  = 1'b0;
    if (rpt_fire) begin
      rpt_on_nxt = 1'b1;
    end else if (held) begin
      rpt_cnt_nxt = rpt_cnt + 32'd1;
      rpt_on_nxt  = rpt_on;
    end
  end

  // Wall lookup for the four neighbours of the current cell; indices need 8 bits (max 164).
  always_comb begin
    idx_up = ({4'd0, player_y} * 8'd10) + {4'd0, player_x};
    idx_dn = idx_up + 8'd10;
    idx_lf = ({4'd0, player_y} * 8'd11) + {4'd0, player_x};
    idx_rt = idx_lf + 8'd1;
`ifdef MAZE_PLAYER_NOCLIP_EN
    wall_up = 1'b0;
    wall_dn = 1'b0;
    wall_lf = 1'b0;
    wall_rt = 1'b0;
`else
    wall_up = h_walls[idx_up];
    wall_dn = h_walls[idx_dn];
    wall_lf = v_walls[idx_lf];
    wall_rt = v_walls[idx_rt];
`endif
  end

  // Target cell and blocked flag for the requested direction.
  always_comb begin
    tx      = player_x;
    ty      = player_y;
    blocked = 1'b1;
    unique case (btn)
      4'b0001: begin blocked = (player_y == 4'd0)  || wall_up; ty = player_y - 4'd1; end
      4'b0010: begin blocked = (player_x == 4'd9)  || wall_rt; tx = player_x + 4'd1; end
      4'b0100: begin blocked = (player_y == 4'd14) || wall_dn; ty = player_y + 4'd1; end
      4'b1000: begin blocked = (player_x == 4'd0)  || wall_lf; tx = player_x - 4'd1; end
      default: ;
    endcase
  end

  // Next-state and next-output logic; a generator restart overrides everything.
  always_comb begin
    state_nxt = state;
    armed_nxt = armed;
    x_nxt     = player_x;
    y_nxt     = player_y;
    cnt_nxt   = move_count;
    bump_nxt  = 1'b0;
    case (state)
      WAIT_GEN: begin
        if (gen_busy) armed_nxt = 1'b1;
        if (armed && !gen_busy) state_nxt = PLAY;
      end
      PLAY: begin
        if (move_req) begin
          if (blocked) begin
            bump_nxt = 1'b1;
          end else begin
            x_nxt = tx;
            y_nxt = ty;
            if (move_count != 10'd1023) cnt_nxt = move_count + 10'd1;
            if (tx == 4'(EXIT_X) && ty == 4'(EXIT_Y)) state_nxt = WON;
          end
        end
      end
      WON: ;
      default: state_nxt = WAIT_GEN;
    endcase
    if (gen_busy && state != WAIT_GEN) begin
      state_nxt = WAIT_GEN;
      armed_nxt = 1'b1;
      x_nxt     = 4'd0;
      y_nxt     = 4'd0;
      cnt_nxt   = 10'd0;
      bump_nxt  = 1'b0;
    end
  end

  // State, position, counters and button history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_GEN;
      armed      <= 1'b0;
      player_x   <= 4'd0;
      player_y   <= 4'd0;
      move_count <= 10'd0;
      bump       <= 1'b0;
      btn_prev   <= 4'd0;
      rpt_cnt    <= 32'd0;
      rpt_on     <= 1'b0;
    end else begin
      state      <= state_nxt;
      armed      <= armed_nxt;
      player_x   <= x_nxt;
      player_y   <= y_nxt;
      move_count <= cnt_nxt;
      bump       <= bump_nxt;
      btn_prev   <= btn;
      rpt_cnt    <= rpt_cnt_nxt;
      rpt_on     <= rpt_on_nxt;
    end
  end

endmodule

// File: tb/tb_maze_player_controller.sv
// Bench for maze_player_controller: directed scenarios plus a random phase, all checked
// every cycle against a move-rule model of the game written from the cell/wall rules.
module tb_maze_player_controller;
  localparam int RD = 4;
  localparam int RP = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [159:0] h_walls = '0;
  logic [164:0] v_walls = '0;
  logic         gen_busy = 1'b0;
  logic [3:0]   btn = 4'd0;
  logic [3:0]   player_x, player_y;
  logic [9:0]   move_count;
  logic         bump, won;

  int vectors = 0;
  int miscompares = 0;

  // model: mode 0 waiting for maze, 1 playing, 2 won
  int         m_mode, m_x, m_y, m_cnt, m_age;
  bit         m_armed, m_bump;
  logic [3:0] m_prev;

  maze_player_controller #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .EXIT_X(9), .EXIT_Y(14)) dut (
    .clk(clk), .rst(rst), .h_walls(h_walls), .v_walls(v_walls), .gen_busy(gen_busy),
    .btn(btn), .player_x(player_x), .player_y(player_y), .move_count(move_count),
    .bump(bump), .won(won)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_armed = 0; m_x = 0; m_y = 0; m_cnt = 0; m_bump = 0; m_age = 0; m_prev = 4'd0;
  endtask

  // Is there a wall between the current cell and neighbour (nx,ny)?
  function automatic bit wall_between(input int nx, input int ny);
    int idx;
`ifdef MAZE_PLAYER_NOCLIP_EN
    return 1'b0;
`else
    if (nx == m_x) begin
      idx = ((m_y > ny) ? m_y : ny) * 10 + m_x;
      return h_walls[8'(idx)];
    end
    idx = m_y * 11 + ((m_x > nx) ? m_x : nx);
    return v_walls[8'(idx)];
`endif
  endfunction

  // One clock edge of the game rules, using the inputs present at that edge.
  task automatic model_step();
    int  nx, ny;
    bit  oh, req, blk;
    if (rst) begin model_reset(); return; end
    oh = ($countones(btn) == 1);
    if (oh && btn == m_prev) m_age++; else m_age = 0;
    req = oh && ((m_prev == 4'd0) || (m_age >= RD && ((m_age - RD) % RP) == 0));
    m_bump = 0;
    if (m_mode != 0 && gen_busy) begin
      m_mode = 0; m_armed = 1; m_x = 0; m_y = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (m_armed && !gen_busy) m_mode = 1;
      if (gen_busy) m_armed = 1;
    end else if (m_mode == 1 && req) begin
      nx = m_x; ny = m_y;
      case (btn)
        4'b0001: ny = m_y - 1;
        4'b0010: nx = m_x + 1;
        4'b0100: ny = m_y + 1;
        default: nx = m_x - 1;
      endcase
      blk = (nx < 0) || (nx > 9) || (ny < 0) || (ny > 14);
      if (!blk) blk = wall_between(nx, ny);
      if (blk) m_bump = 1;
      else begin
        m_x = nx; m_y = ny;
        if (m_cnt < 1023) m_cnt++;
        if (nx == 9 && ny == 14) m_mode = 2;
      end
    end
    m_prev = btn;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("player_x", 32'(player_x), 32'(m_x));
    chk("player_y", 32'(player_y), 32'(m_y));
    chk("move_count", 32'(move_count), 32'(m_cnt));
    chk("bump", 32'(bump), 32'(m_bump));
    chk("won", 32'(won), 32'(m_mode == 2));
  endtask

  task automatic press(input logic [3:0] b);
    btn = b; tick();
    btn = 4'd0; tick();
  endtask

  task automatic restart();
    gen_busy = 1'b1; tick();
    gen_busy = 1'b0; tick();
  endtask

  initial begin
    model_reset();
    #3;
    chk("reset_x", 32'(player_x), 32'd0);
    chk("reset_y", 32'(player_y), 32'd0);
    chk("reset_cnt", 32'(move_count), 32'd0);
    chk("reset_bump", 32'(bump), 32'd0);
    chk("reset_won", 32'(won), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // gen_busy never seen: buttons ignored
    for (int i = 0; i < 6; i++) press(4'b0010);
    press(4'b0100);

    // generator busy for 10 cycles, then idle
    gen_busy = 1'b1;
    repeat (10) tick();
    gen_busy = 1'b0;
    tick();

    // everything walled: right bumps; open walls: up bumps on the boundary
    h_walls = '1; v_walls = '1;
    press(4'b0010);
    h_walls = '0; v_walls = '0;
    btn = 4'b0001; tick();
    chk("up_bump", 32'(bump), 32'd1);
    btn = 4'd0; tick();

    // hold right: auto-repeat to the east edge, then bumps
    btn = 4'b0010;
    repeat (26) tick();
    chk("hold_x", 32'(player_x), 32'd9);
    chk("hold_cnt", 32'(move_count), 32'd9);
    btn = 4'd0; tick();

    // two buttons together do nothing
    btn = 4'b0011;
    repeat (20) tick();
    btn = 4'd0; tick();
    press(4'b0100);
    chk("after_chord_y", 32'(player_y), 32'd1);

    // walk to the exit
    restart();
    for (int i = 0; i < 9; i++) press(4'b0010);
    for (int i = 0; i < 14; i++) press(4'b0100);
    chk("exit_won", 32'(won), 32'd1);
    chk("exit_cnt", 32'(move_count), 32'd23);
    press(4'b1000);
    press(4'b0001);
    gen_busy = 1'b1; tick();
    chk("restart_won", 32'(won), 32'd0);
    chk("restart_cnt", 32'(move_count), 32'd0);
    gen_busy = 1'b0; tick();

    // random phase
    for (int c = 0; c < 1500; c++) begin
      int r;
      if (c % 64 == 0) begin
        for (int i = 0; i < 160; i++) h_walls[i] = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 165; i++) v_walls[i] = ($urandom_range(0, 3) == 0);
      end
      r = $urandom_range(0, 9);
      if (r == 6) btn = 4'd0;
      else if (r == 7 || r == 8) btn = 4'(1 << $urandom_range(0, 3));
      else if (r == 9) btn = 4'($urandom);
      gen_busy = ($urandom_range(0, 199) == 0);
      tick();
    end

    // go to (2,2), then hold right and reset asynchronously at (3,2)
    gen_busy = 1'b0; btn = 4'd0; h_walls = '0; v_walls = '0;
    tick();
    restart();
    press(4'b0010); press(4'b0010);
    press(4'b0100); press(4'b0100);
    btn = 4'b0010; tick(); tick();
    chk("pre_rst_x", 32'(player_x), 32'd3);
    chk("pre_rst_y", 32'(player_y), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_x", 32'(player_x), 32'd0);
    chk("async_y", 32'(player_y), 32'd0);
    chk("async_cnt", 32'(move_count), 32'd0);
    model_reset();
    tick(); tick();
    rst = 1'b0;
    btn = 4'd0; tick();
    for (int i = 0; i < 4; i++) press(4'b0010);
    chk("post_rst_x", 32'(player_x), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
